// File: rtl/gram_arb_pkg.sv
// Shared types and constants for the GRAM port arbiter.
package gram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned REQ_LOAD = 0;
    localparam int unsigned REQ_MOVE = 1;
    localparam int unsigned REQ_AUX  = 2;

    localparam int unsigned GRAM_ADDR_W = 9;
    localparam int unsigned GRAM_DATA_W = 4;

    // Width of a requester index, never zero.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selection: first request at or after ptr+1, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gram_port_arbiter.sv
// Round-robin owner of the single GRAM port with bounded bursts and read-response routing.
module gram_port_arbiter
    import gram_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned ADDR_W    = GRAM_ADDR_W,
    parameter int unsigned DATA_W    = GRAM_DATA_W,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ram_wea,
    output logic                     ram_rea,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic                     busy
);

    localparam int unsigned PTR_W  = idx_w(N_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_SAT  = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    arb_state_e        state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  ptr;
    logic [BEAT_W-1:0] beat;
    logic [PTR_W-1:0]  rd_id;

    logic [N_REQ-1:0]  pick_oh;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic              force_rel;

    logic [RD_LAT-1:0] tag_v;
    logic [PTR_W-1:0]  tag_id [RD_LAT];

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) pick_idx = PTR_W'(i);
        end
    end

    // Beat counter saturates, so >= also catches a competitor arriving late in a lone run.
    assign force_rel = ~lock[owner] & (|(req & ~gnt)) & (beat >= LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            ptr       <= PTR_W'(N_REQ - 1);
            beat      <= '0;
            rd_id     <= '0;
            ram_wea   <= 1'b0;
            ram_rea   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_wea <= 1'b0;
            ram_rea <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                        beat  <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (req[owner]) begin
                        ram_wea   <= we[owner];
                        ram_rea   <= ~we[owner];
                        ram_addr  <= addr[owner*ADDR_W +: ADDR_W];
                        ram_wdata <= wdata[owner*DATA_W +: DATA_W];
                        rd_id     <= owner;
                        if (beat != BEAT_SAT) beat <= beat + 1'b1;
                        if (force_rel) begin
                            gnt   <= '0;
                            ptr   <= owner;
                            state <= IDLE;
                        end
                    end else begin
                        gnt   <= '0;
                        ptr   <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 sits one cycle behind ram_rea; the last stage lines up with ram_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= ram_rea;
            tag_id[0] <= rd_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (tag_v[RD_LAT-1]) rvalid[tag_id[RD_LAT-1]] = 1'b1;
    end

    assign rdata = ram_rdata;
    assign busy  = (state == OWN) | ram_rea | (|tag_v);

endmodule

// File: tb/tb_gram_port_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) share stimulus, checked against hand values.
module tb_gram_port_arbiter;
    import gram_arb_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = GRAM_ADDR_W;
    localparam int unsigned DW = GRAM_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NR-1:0]    req, lock, we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [DW-1:0]    ram_rdata;

    logic [NR-1:0] gnt1, rvalid1, gnt3, rvalid3;
    logic [DW-1:0] rdata1, rwdata1, rdata3, rwdata3;
    logic [AW-1:0] raddr1, raddr3;
    logic wea1, rea1, busy1, wea3, rea3, busy3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(16)) u_dut1 (
        .clk (clk), .rst (rst), .req (req), .lock (lock), .we (we), .addr (addr),
        .wdata (wdata), .gnt (gnt1), .rvalid (rvalid1), .rdata (rdata1), .ram_wea (wea1),
        .ram_rea (rea1), .ram_addr (raddr1), .ram_wdata (rwdata1), .ram_rdata (ram_rdata),
        .busy (busy1)
    );

    gram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(16)) u_dut3 (
        .clk (clk), .rst (rst), .req (req), .lock (lock), .we (we), .addr (addr),
        .wdata (wdata), .gnt (gnt3), .rvalid (rvalid3), .rdata (rdata3), .ram_wea (wea3),
        .ram_rea (rea3), .ram_addr (raddr3), .ram_wdata (rwdata3), .ram_rdata (ram_rdata),
        .busy (busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = '0;
        lock = '0;
        we   = '0;
        tick();
        rst  = 1'b1;
    endtask

    // Entered right after gnt==cur rose; expects 16 writes, forced release, one idle cycle.
    task automatic run_grant(input string tag, input logic [NR-1:0] cur, input logic [NR-1:0] nxt,
                             input logic [AW-1:0] exp_addr);
        int nwe  = 0;
        int hold = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (wea1) nwe++;
            if (k < 16 && gnt1 == cur) hold++;
        end
        check({tag, " accesses"}, nwe, 16);
        check({tag, " hold"}, hold, 15);
        check({tag, " last addr"}, raddr1, exp_addr);
        check({tag, " forced release"}, gnt1, 0);
        tick();
        check({tag, " gap no access"}, wea1, 0);
        check({tag, " regrant"}, gnt1, nxt);
    endtask

    initial begin
        int n;
        int h;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0; ram_rdata = '0;
        tick();
        tick();
        check("reset gnt", gnt1, 0);
        check("reset busy", busy1, 0);
        check("reset wea", wea1, 0);
        check("reset rea", rea1, 0);
        check("reset addr", raddr1, 0);
        check("reset rvalid3", rvalid3, 0);
        rst = 1'b1;

        // Single write by requester 0, then normal release.
        req = 3'b011; we = 3'b001;
        addr[0*AW +: AW] = 9'h005; wdata[0*DW +: DW] = 4'hA;
        tick();
        check("t1 grant", gnt1, 3'b001);
        check("t1 no access in idle", wea1, 0);
        tick();
        check("t1 wea", wea1, 1);
        check("t1 rea", rea1, 0);
        check("t1 addr", raddr1, 9'h005);
        check("t1 wdata", rwdata1, 4'hA);
        check("t1 gnt held", gnt1, 3'b001);
        req = 3'b010;
        tick();
        check("t1 release", gnt1, 0);
        check("t1 release no access", wea1, 0);
        tick();
        check("t1 regrant", gnt1, 3'b010);

        // Read by requester 1, response routed by latency.
        we = 3'b000; addr[1*AW +: AW] = 9'h005; ram_rdata = 4'hA;
        tick();
        check("t2 rea", rea1, 1);
        check("t2 wea", wea1, 0);
        check("t2 addr", raddr1, 9'h005);
        check("t2 rvalid early", rvalid1, 0);
        req = 3'b000;
        tick();
        check("t2 rvalid", rvalid1, 3'b010);
        check("t2 rdata", rdata1, 4'hA);
        check("t2 rea low", rea1, 0);
        check("t2 gnt released", gnt1, 0);
        tick();
        check("t2 rvalid done", rvalid1, 0);
        check("t2 busy1 idle", busy1, 0);
        check("t2 busy3 in flight", busy3, 1);
        check("t2 rvalid3 early", rvalid3, 0);
        tick();
        check("t2 rvalid3", rvalid3, 3'b010);
        check("t2 rdata3", rdata3, 4'hA);
        tick();

        // Round-robin with forced release after 16 beats.
        do_reset();
        req = 3'b101; we = 3'b111;
        addr[0*AW +: AW] = 9'h010; addr[2*AW +: AW] = 9'h012;
        tick();
        check("rr first grant", gnt1, 3'b001);
        for (int r = 0; r < 4; r++) begin
            run_grant("rr req0", 3'b001, 3'b100, 9'h010);
            run_grant("rr req2", 3'b100, 3'b001, 9'h012);
        end

        // Lone requester runs past MAX_BURST; a late competitor triggers release at once.
        do_reset();
        req = 3'b001; we = 3'b001;
        tick();
        check("lone grant", gnt1, 3'b001);
        repeat (20) tick();
        check("lone hold", gnt1, 3'b001);
        check("lone access", wea1, 1);
        req = 3'b101;
        tick();
        check("late competitor release", gnt1, 0);
        check("late competitor last access", wea1, 1);
        tick();
        check("late competitor grant", gnt1, 3'b100);

        // Lock suppresses forced release.
        do_reset();
        req = 3'b101; lock = 3'b001; we = 3'b101;
        tick();
        check("lock grant", gnt1, 3'b001);
        n = 0; h = 0;
        repeat (40) begin
            tick();
            if (wea1) n++;
            if (gnt1 == 3'b001) h++;
        end
        check("lock accesses", n, 40);
        check("lock hold", h, 40);
        req = 3'b100;
        tick();
        check("lock release", gnt1, 0);
        check("lock release no access", wea1, 0);
        tick();
        check("lock next grant", gnt1, 3'b100);
        lock = 3'b000;

        // Read in the last beat of a forced release, RD_LAT=3.
        do_reset();
        req = 3'b101; we = 3'b101;
        tick();
        check("t5 grant", gnt3, 3'b001);
        repeat (15) tick();
        we = 3'b100;
        tick();
        check("t5 final read", rea3, 1);
        check("t5 forced release", gnt3, 0);
        we = 3'b101;
        tick();
        check("t5 regrant", gnt3, 3'b100);
        check("t5 rvalid3 c1", rvalid3, 0);
        tick();
        check("t5 rvalid3 c2", rvalid3, 0);
        tick();
        check("t5 rvalid3 to req0", rvalid3, 3'b001);
        check("t5 gnt during response", gnt3, 3'b100);

        // Asynchronous reset mid-burst.
        tick();
        #1 rst = 1'b0;
        #1;
        check("t6 gnt", gnt3, 0);
        check("t6 wea", wea3, 0);
        check("t6 rea", rea3, 0);
        check("t6 addr", raddr3, 0);
        check("t6 busy", busy3, 0);
        check("t6 rvalid", rvalid3, 0);
        check("t6 gnt1", gnt1, 0);
        req = 3'b111;
        tick();
        rst = 1'b1;
        tick();
        check("t6 first grant after reset", gnt1, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gram_port_arbiter.md
Name: gram_port_arbiter

Overview:
- Shares the single GRAM read/write port between requesters through a registered req/gnt handshake.
- Requesters: level loader (0), move engine (1), auxiliary editor/debug source (2).
- Replaces the ad-hoc priority muxing of GRAM address, data and enables in the top level.
- Round-robin fairness; burst ownership with optional lock; bounded burst length; read responses routed back to the issuing requester.

Parameters:
- N_REQ, 3, number of requesters.
- ADDR_W, 9, GRAM address width.
- DATA_W, 4, GRAM data width.
- RD_LAT, 1, GRAM read latency (ram_rea cycle to ram_rdata valid), range 1..3.
- MAX_BURST, 16, accesses per grant before forced release when others wait and lock=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  N_REQ  request / hold ownership, one bit per requester.
- lock  in  N_REQ  suppress MAX_BURST forced release while owner.
- we  in  N_REQ  1=write, 0=read, per requester.
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed write data.
- gnt  out  N_REQ  registered one-hot grant.
- rvalid  out  N_REQ  read data valid, one-hot by issuing requester.
- rdata  out  DATA_W  read data, shared by all requesters.
- ram_wea  out  1  GRAM write enable.
- ram_rea  out  1  GRAM read enable.
- ram_addr  out  ADDR_W  GRAM address.
- ram_wdata  out  DATA_W  GRAM write data.
- ram_rdata  in  DATA_W  GRAM read data.
- busy  out  1  high while any grant is held or reads are in flight.

Behaviour:
- Reset (rst low, asynchronous):
  - gnt=0, rvalid=0, ram_wea=0, ram_rea=0, ram_addr=0, ram_wdata=0, busy=0.
  - State IDLE, beat counter=0, last-grant pointer=N_REQ-1, so requester 0 wins first.
  - Read tag pipeline flushed. Reset during a burst drops the access in progress without completing it.
- State IDLE:
  - If any req is high, pick the first requester set at or after pointer+1, wrapping modulo N_REQ.
  - gnt[winner] rises on the next edge; state becomes OWN; beat counter cleared.
  - No GRAM access is issued in IDLE.
- State OWN, each cycle with req[o]&gnt[o]:
  - One access is accepted. At the next edge: ram_wea<=we[o], ram_rea<=~we[o], ram_addr<=addr[o], ram_wdata<=wdata[o]. Access latency is therefore 1 cycle to the port.
  - Beat counter increments.
  - ram_wea and ram_rea are never high together and are low in every cycle with no accepted access.
- Release, normal: owner drops req. No access that cycle; gnt clears next edge; state IDLE; pointer=owner.
- Release, forced: if lock[o]=0, another req is pending, and the accepted access is beat MAX_BURST-1, that access completes and gnt clears next edge. The owner keeps req high and waits for a re-grant.
- Minimum gap: exactly one IDLE cycle between consecutive grants, for both normal and forced release.
- Lone requester: with no competitor, ownership continues past MAX_BURST; the beat counter saturates.
- req rising in the grant cycle is legal. A req low in the first gnt cycle is a zero-beat release.
- Reads:
  - Each read pushes the owner id into an RD_LAT-deep tag shift register aligned with ram_rea.
  - rvalid[id] is high in the cycle ram_rdata is valid; rdata=ram_rdata passed through combinationally.
  - Responses in flight are delivered even after gnt moves to another requester.
- Ordering: accesses reach GRAM in issue order, so read-after-write to the same address returns the new data.
- busy = (state==OWN) | any tag valid.
- Invariants: gnt is always one-hot or zero; gnt never changes in a cycle where the owner holds req and no release condition is met.

Decomposition:
- Package gram_arb_pkg holds:
  - state enum {IDLE, OWN};
  - requester ids REQ_LOAD=0, REQ_MOVE=1, REQ_AUX=2;
  - default widths ADDR_W=9, DATA_W=4.
- Sub-module rr_picker: combinational round-robin selection, inputs req vector and pointer, outputs one-hot winner and valid.
- Tag pipeline, beat counter and FSM stay in the top block.

Test Plan:
- Reset, then req=3'b011: gnt=3'b001 on the 2nd edge. Requester 0 writes addr 0x05 data 0xA, then drops req. Next edge: ram_wea=1, ram_addr=0x05. After one IDLE cycle, gnt=3'b010.
- Requester 1 owns; read addr 0x05 with RD_LAT=1 and RAM returning 0xA. ram_rea=1 one edge later; rvalid=3'b010 with rdata=0xA the following cycle.
- req[0] and req[2] held continuously, lock=0: requester 0 performs exactly 16 accesses; gnt goes 0 for one cycle, then gnt=3'b100. Round-robin alternation holds for 4 rounds.
- Same as above with lock[0]=1: requester 0 keeps gnt beyond 40 accesses; requester 2 is granted only after req[0] drops.
- Read issued in the final beat of a forced release with RD_LAT=3: rvalid[0] pulses 3 cycles after ram_rea while gnt=3'b100. No rvalid to requester 2.
- rst pulled low mid-burst: all outputs are 0 immediately. After release, req=3'b111 is granted to requester 0 first.
